// File: rtl/otter_io_timer_if.sv
// OTTER MCU I/O bus: address, write data, write strobe and read data.
// The master is the MCU; the slave is the peripheral responder.
interface otter_io_timer_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;

  modport master (
    output IOBUS_ADDR,
    output IOBUS_OUT,
    output IOBUS_WR,
    input  IOBUS_IN
  );

  modport slave (
    input  IOBUS_ADDR,
    input  IOBUS_OUT,
    input  IOBUS_WR,
    output IOBUS_IN
  );
endinterface

// File: rtl/otter_io_timer.sv
// OTTER I/O responder: switches, LED register and prescaled interrupt timer.
// Define OTTER_IO_SW_SYNC_EN to pass SW through a two-flop synchronizer.
module otter_io_timer #(
  parameter int unsigned PRESCALE  = 50,
  parameter int unsigned SW_WIDTH  = 16,
  parameter int unsigned LED_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  otter_io_timer_if.slave      bus,
  input  logic [SW_WIDTH-1:0]  SW,
  output logic [LED_WIDTH-1:0] LEDS,
  output logic                 INT
);

  localparam logic [31:0] A_SW   = 32'h1100_0000;
  localparam logic [31:0] A_LED  = 32'h1108_0000;
  localparam logic [31:0] A_CTRL = 32'h1110_0000;
  localparam logic [31:0] A_LOAD = 32'h1110_0004;
  localparam logic [31:0] A_CNT  = 32'h1110_0008;
  localparam logic [31:0] A_STAT = 32'h1110_000C;

  localparam logic [15:0] PSC_MAX = 16'(PRESCALE - 1);

  logic [2:0]  ctrl;
  logic [31:0] load;
  logic [31:0] count;
  logic [15:0] psc;
  logic        exp_q;

  logic [SW_WIDTH-1:0] sw_q;

`ifdef OTTER_IO_SW_SYNC_EN
  logic [SW_WIDTH-1:0] sw_m;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sw_m <= '0;
      sw_q <= '0;
    end else begin
      sw_m <= SW;
      sw_q <= sw_m;
    end
  end
`else
  assign sw_q = SW;
`endif

  logic sel_sw, sel_led, sel_ctrl;
  logic sel_load, sel_cnt, sel_stat;

  assign sel_sw   = bus.IOBUS_ADDR == A_SW;
  assign sel_led  = bus.IOBUS_ADDR == A_LED;
  assign sel_ctrl = bus.IOBUS_ADDR == A_CTRL;
  assign sel_load = bus.IOBUS_ADDR == A_LOAD;
  assign sel_cnt  = bus.IOBUS_ADDR == A_CNT;
  assign sel_stat = bus.IOBUS_ADDR == A_STAT;

  logic wr_led, wr_ctrl, wr_load, wr_stat;

  assign wr_led  = bus.IOBUS_WR & sel_led;
  assign wr_ctrl = bus.IOBUS_WR & sel_ctrl;
  assign wr_load = bus.IOBUS_WR & sel_load;
  assign wr_stat = bus.IOBUS_WR & sel_stat;

  logic tick, cnt_zero, expire;

  assign tick     = ctrl[0] & (psc == PSC_MAX);
  assign cnt_zero = count == 32'd0;
  assign expire   = tick & cnt_zero;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      psc <= '0;
    end else if (wr_load || !ctrl[0] || tick) begin
      psc <= '0;
    end else begin
      psc <= psc + 16'd1;
    end
  end

  // A LOAD write overrides the tick's decrement or reload.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
      load  <= '0;
    end else if (wr_load) begin
      count <= bus.IOBUS_OUT;
      load  <= bus.IOBUS_OUT;
    end else if (tick) begin
      if (!cnt_zero) begin
        count <= count - 32'd1;
      end else if (ctrl[1]) begin
        count <= load;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ctrl <= '0;
    end else if (wr_ctrl) begin
      ctrl <= bus.IOBUS_OUT[2:0];
    end else if (expire && !ctrl[1]) begin
      ctrl[0] <= 1'b0;
    end
  end

  // Expiry beats a simultaneous W1C.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      exp_q <= 1'b0;
    end else if (expire) begin
      exp_q <= 1'b1;
    end else if (wr_stat && bus.IOBUS_OUT[0]) begin
      exp_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      LEDS <= '0;
    end else if (wr_led) begin
      LEDS <= bus.IOBUS_OUT[LED_WIDTH-1:0];
    end
  end

  assign INT = exp_q & ctrl[2];

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_sw:   rdata = 32'(sw_q);
      sel_led:  rdata = 32'(LEDS);
      sel_ctrl: rdata = 32'(ctrl);
      sel_load: rdata = load;
      sel_cnt:  rdata = count;
      sel_stat: rdata = 32'(exp_q);
      default:  rdata = '0;
    endcase
  end

  assign bus.IOBUS_IN = rdata;

endmodule

// File: tb/tb_otter_io_timer.sv
// Bench for otter_io_timer: vector table, timer corner sequences,
// and random bus traffic against a behavioural model.
module tb_otter_io_timer;

  localparam int P = 4;

  localparam logic [31:0] A_SW   = 32'h1100_0000;
  localparam logic [31:0] A_LED  = 32'h1108_0000;
  localparam logic [31:0] A_CTRL = 32'h1110_0000;
  localparam logic [31:0] A_LOAD = 32'h1110_0004;
  localparam logic [31:0] A_CNT  = 32'h1110_0008;
  localparam logic [31:0] A_STAT = 32'h1110_000C;

  logic        clk;
  logic        rst_n;
  logic [15:0] sw;
  logic [15:0] leds;
  logic        irq;

  otter_io_timer_if bus ();

  otter_io_timer #(
    .PRESCALE (P),
    .SW_WIDTH (16),
    .LED_WIDTH(16)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus.slave),
    .SW   (sw),
    .LEDS (leds),
    .INT  (irq)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  // Behavioural model of the register file and timer.
  logic [15:0] m_leds;
  logic [2:0]  m_ctrl;
  logic [31:0] m_load;
  logic [31:0] m_count;
  int          m_psc;
  logic        m_exp;
`ifdef OTTER_IO_SW_SYNC_EN
  logic [15:0] m_s1, m_s2;
`endif

  task automatic m_reset();
    m_leds  = '0;
    m_ctrl  = '0;
    m_load  = '0;
    m_count = '0;
    m_psc   = 0;
    m_exp   = 1'b0;
`ifdef OTTER_IO_SW_SYNC_EN
    m_s1 = '0;
    m_s2 = '0;
`endif
  endtask

  function automatic logic [15:0] m_sw();
`ifdef OTTER_IO_SW_SYNC_EN
    return m_s2;
`else
    return sw;
`endif
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    case (a)
      A_SW:    return {16'h0, m_sw()};
      A_LED:   return {16'h0, m_leds};
      A_CTRL:  return {29'h0, m_ctrl};
      A_LOAD:  return m_load;
      A_CNT:   return m_count;
      A_STAT:  return {31'h0, m_exp};
      default: return 32'h0;
    endcase
  endfunction

  // Apply the rules for one rising edge given the current bus inputs.
  task automatic model_edge();
    bit          tk;
    bit          set_exp;
    logic [2:0]  n_ctrl;
    logic [31:0] n_count;
    int          n_psc;
    logic [31:0] a;
    logic [31:0] d;
    if (!rst_n) begin
      m_reset();
      return;
    end
    a = bus.IOBUS_ADDR;
    d = bus.IOBUS_OUT;
    tk = m_ctrl[0] && (m_psc == P - 1);
    set_exp = tk && (m_count == 0);
    n_ctrl = m_ctrl;
    n_count = m_count;
    n_psc = (!m_ctrl[0] || tk) ? 0 : m_psc + 1;
    if (tk) begin
      if (m_count != 0) n_count = m_count - 1;
      else if (m_ctrl[1]) n_count = m_load;
      else n_ctrl[0] = 1'b0;
    end
    if (set_exp) m_exp = 1'b1;
    if (bus.IOBUS_WR) begin
      case (a)
        A_LED:  m_leds = d[15:0];
        A_CTRL: n_ctrl = d[2:0];
        A_LOAD: begin
          m_load = d;
          n_count = d;
          n_psc = 0;
        end
        A_STAT: if (d[0] && !set_exp) m_exp = 1'b0;
        default: ;
      endcase
    end
    m_ctrl = n_ctrl;
    m_count = n_count;
    m_psc = n_psc;
`ifdef OTTER_IO_SW_SYNC_EN
    m_s2 = m_s1;
    m_s1 = sw;
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus.IOBUS_ADDR = a;
    bus.IOBUS_OUT  = d;
    bus.IOBUS_WR   = 1'b1;
    step();
    bus.IOBUS_WR   = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a,
                        input logic [31:0] exp);
    bus.IOBUS_ADDR = a;
    #1;
    chk(nm, bus.IOBUS_IN, exp);
  endtask

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] rexp;
    logic [15:0] lexp;
  } vec_t;

  vec_t vt[12];
  logic [31:0] amap[8];

  initial begin
    int k;
    logic [31:0] a;
    logic [31:0] d;

    vt[0]  = '{A_LED,  32'h0000_A5A5, A_LED,  32'h0000_A5A5, 16'hA5A5};
    vt[1]  = '{A_SW,   32'hFFFF_FFFF, A_SW,   32'h0000_3C3C, 16'hA5A5};
    vt[2]  = '{A_LED,  32'hFFFF_1234, A_LED,  32'h0000_1234, 16'h1234};
    vt[3]  = '{32'h1108_0004, 32'h5, 32'h1108_0004, 32'h0, 16'h1234};
    vt[4]  = '{A_LOAD, 32'hDEAD_BEEF, A_LOAD, 32'hDEAD_BEEF, 16'h1234};
    vt[5]  = '{A_CNT,  32'h0000_0005, A_CNT,  32'hDEAD_BEEF, 16'h1234};
    vt[6]  = '{A_CTRL, 32'hFFFF_FFF8, A_CTRL, 32'h0,         16'h1234};
    vt[7]  = '{A_CTRL, 32'h0000_0002, A_CTRL, 32'h2,         16'h1234};
    vt[8]  = '{32'h1100_0004, 32'h7, 32'h1100_0004, 32'h0, 16'h1234};
    vt[9]  = '{A_LOAD, 32'h0,         A_CNT,  32'h0,         16'h1234};
    vt[10] = '{A_CTRL, 32'h0,         A_CTRL, 32'h0,         16'h1234};
    vt[11] = '{A_STAT, 32'h1,         A_STAT, 32'h0,         16'h1234};

    amap = '{A_SW, A_LED, A_CTRL, A_LOAD, A_CNT, A_STAT,
             32'h1100_0004, 32'h1110_0010};

    bus.IOBUS_ADDR = '0;
    bus.IOBUS_OUT  = '0;
    bus.IOBUS_WR   = 1'b0;
    sw    = 16'h3C3C;
    rst_n = 1'b1;
    m_reset();
    #2 rst_n = 1'b0;
    step();
    step();
    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rst_count", A_CNT, 32'h0);
    rst_n = 1'b1;
    step();
    step();
    rd_chk("init_leds", A_LED, 32'h0);
    rd_chk("init_ctrl", A_CTRL, 32'h0);
    rd_chk("init_load", A_LOAD, 32'h0);
    rd_chk("init_count", A_CNT, 32'h0);
    rd_chk("init_status", A_STAT, 32'h0);
    rd_chk("init_sw", A_SW, 32'h0000_3C3C);
    rd_chk("init_gap", 32'h1100_0004, 32'h0);
    chk("init_int", irq, 0);
    step();

    for (int i = 0; i < 12; i++) begin
      bus_wr(vt[i].waddr, vt[i].wdata);
      rd_chk($sformatf("vec%0d_rd", i), vt[i].raddr, vt[i].rexp);
      chk($sformatf("vec%0d_leds", i), leds, vt[i].lexp);
    end

    // One-shot: LOAD=3, EN|IE.
    bus_wr(A_LOAD, 32'd3);
    bus_wr(A_CTRL, 32'h5);
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      k = c;
      if (irq) break;
    end
    chk("oneshot_latency", k, 16);
    rd_chk("oneshot_ctrl", A_CTRL, 32'h4);
    rd_chk("oneshot_count", A_CNT, 32'h0);
    rd_chk("oneshot_exp", A_STAT, 32'h1);
    repeat (4) step();
    rd_chk("oneshot_hold", A_CNT, 32'h0);
    chk("oneshot_int_hold", irq, 1);
    bus_wr(A_STAT, 32'h1);
    chk("oneshot_w1c", irq, 0);

    // Periodic: LOAD=1, EN|RELOAD|IE.
    bus_wr(A_LOAD, 32'd1);
    bus_wr(A_CTRL, 32'h7);
    rd_chk("per_count0", A_CNT, 32'h1);
    for (int s = 1; s <= 16; s++) begin
      step();
      bus.IOBUS_WR = 1'b0;
      chk($sformatf("per_int%0d", s), irq, (s == 8 || s == 16) ? 1 : 0);
      if (s % 4 == 0)
        rd_chk($sformatf("per_cnt%0d", s), A_CNT, (s % 8 == 0) ? 1 : 0);
      if (s == 8) begin
        bus.IOBUS_ADDR = A_STAT;
        bus.IOBUS_OUT  = 32'h1;
        bus.IOBUS_WR   = 1'b1;
      end
    end
    bus_wr(A_CTRL, 32'h3);
    rd_chk("per_noie_exp", A_STAT, 32'h1);
    chk("per_noie_int", irq, 0);

    // W1C on the same edge as an expiry.
    bus_wr(A_CTRL, 32'h7);
    bus_wr(A_LOAD, 32'd1);
    bus_wr(A_STAT, 32'h1);
    chk("race_cleared", irq, 0);
    repeat (6) step();
    chk("race_pre", irq, 0);
    bus_wr(A_STAT, 32'h1);
    rd_chk("race_exp", A_STAT, 32'h1);
    chk("race_int", irq, 1);
    step();
    chk("race_int_hold", irq, 1);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      sw = 16'($urandom);
      a = amap[$urandom_range(0, 7)];
      d = (a == A_LOAD) ? 32'($urandom_range(0, 6)) : $urandom;
      bus.IOBUS_ADDR = a;
      bus.IOBUS_OUT  = d;
      bus.IOBUS_WR   = ($urandom_range(0, 2) == 0);
      step();
      bus.IOBUS_WR = 1'b0;
      chk($sformatf("rnd%0d_int", i), irq, m_exp & m_ctrl[2]);
      chk($sformatf("rnd%0d_leds", i), leds, m_leds);
      a = amap[$urandom_range(0, 7)];
      rd_chk($sformatf("rnd%0d_rd", i), a, mread(a));
    end

    // Reset mid-count with EXP pending.
    sw = 16'h3C3C;
    bus_wr(A_LOAD, 32'd0);
    bus_wr(A_CTRL, 32'h7);
    repeat (5) step();
    bus_wr(A_LOAD, 32'h10);
    bus_wr(A_CTRL, 32'h5);
    chk("mid_int", irq, 1);
    rd_chk("mid_count", A_CNT, 32'h10);
    #2 rst_n = 1'b0;
    rd_chk("arst_count", A_CNT, 32'h0);
    rd_chk("arst_ctrl", A_CTRL, 32'h0);
    chk("arst_int", irq, 0);
    chk("arst_leds", leds, 0);
    step();
    step();
    rst_n = 1'b1;
    k = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (irq) k++;
    end
    chk("post_rst_int", k, 0);
    rd_chk("post_rst_count", A_CNT, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/otter_io_timer.md
# otter_io_timer

Memory-mapped I/O responder on the OTTER MCU I/O bus: the device end of the `IOBUS_ADDR` / `IOBUS_OUT` / `IOBUS_WR` / `IOBUS_IN` interface.
- Decodes bus addresses and holds the board LED register.
- Returns switch values and timer state on `IOBUS_IN`.
- Contains a prescaled down-counting timer whose expiry drives the MCU `INT` input.

## Interface
- `PRESCALE`, 50: CLK cycles per timer tick, legal range 1..65535.
- `SW_WIDTH`, 16: number of switch inputs.
- `LED_WIDTH`, 16: number of LED outputs.
- `CLK` in 1: the only clock; all state updates on its rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `IOBUS_ADDR` in 32: byte address from the MCU.
- `IOBUS_OUT` in 32: write data from the MCU.
- `IOBUS_WR` in 1: write strobe, one cycle per store.
- `IOBUS_IN` out 32: read data to the MCU.
- `SW` in SW_WIDTH: board switches, asynchronous to CLK.
- `LEDS` out LED_WIDTH: LED register.
- `INT` out 1: interrupt request to the MCU.

## Operation
Address map (full 32-bit compare):
- `0x1100_0000` SWITCHES, read-only. Value is `SW` zero-extended.
- `0x1108_0000` LEDS, read/write. Bits above LED_WIDTH read 0.
- `0x1110_0000` CTRL, read/write, bits [2:0]; other bits read 0.
  - bit0 EN: counter runs.
  - bit1 RELOAD: periodic mode when 1, one-shot when 0.
  - bit2 IE: interrupt enable.
- `0x1110_0004` LOAD, read/write, 32 bits.
- `0x1110_0008` COUNT, read-only, 32 bits.
- `0x1110_000C` STATUS, bit0 EXP.
  - Writing 1 to bit0 clears EXP; writing 0 has no effect.

Bus rules:
- Unmapped addresses read 0; writes to them are ignored.
- Writes to read-only registers are ignored.

Timer:
- Prescaler counts 0..PRESCALE-1 while EN=1. A tick is the cycle in which the prescaler equals PRESCALE-1; the prescaler then wraps to 0.
- While EN=0 the prescaler holds at 0.
- On each tick:
  - If COUNT≠0: COUNT decrements by 1.
  - If COUNT=0: EXP is set. Then, if RELOAD=1, COUNT←LOAD; if RELOAD=0, EN←0 and COUNT stays 0.
- Writing LOAD also sets COUNT←LOAD and resets the prescaler to 0.
- Period is therefore (LOAD+1)·PRESCALE cycles.
- `INT` = EXP & IE, as a level. It stays high until software clears EXP or IE.

Simultaneous events:
- Expiry tick in the same cycle as a STATUS W1C: EXP remains 1 (set wins).
- CTRL write in the same cycle as a tick: the CTRL value written wins. The tick's COUNT update is still applied.
- LOAD write in the same cycle as a tick: the LOAD write wins, so COUNT←new LOAD and no decrement occurs. EXP is still set if COUNT was 0.
- LOAD=0 with RELOAD=1: EXP is set on every tick.

## Timing
Reset (`RST_N` low, asynchronous) clears all state immediately:
- LEDS=0, CTRL=0, LOAD=0, COUNT=0, prescaler=0, EXP=0, so INT=0.
- IOBUS_IN goes to 0 if IOBUS_ADDR is unmapped; otherwise it reflects the reset register values.
- Reset asserted mid-count abandons the count. No expiry occurs on reset release.

Read and write latency:
- Reads are combinational: `IOBUS_IN` reflects `IOBUS_ADDR` in the same cycle, with no wait states and no handshake.
- Writes take effect at the rising edge where `IOBUS_WR`=1. The new value is visible on reads and `LEDS` in the following cycle.
- EXP sets at the edge ending the tick cycle. `INT` rises in the same cycle EXP becomes 1; there is no extra register.

## Configuration
- `OTTER_IO_SW_SYNC_EN` defined: `SW` passes through a two-flop synchronizer, reset to 0. SWITCHES reads reflect a `SW` change 2 cycles later.
- Not defined: SWITCHES reads `SW` combinationally, with 0-cycle latency.

## Test plan
- Reset release, then a read of every mapped address → LEDS/CTRL/LOAD/COUNT/STATUS all read 0, and `INT`=0.
  - SWITCHES reads `SW` (latency 2 with `OTTER_IO_SW_SYNC_EN`, 0 without).
  - Address `0x1100_0004` reads 0.
- Write `0x0000_A5A5` to LEDS → `LEDS`=`0xA5A5` the next cycle and reads back `0x0000_A5A5`.
  - Then a write to SWITCHES leaves the switch readback unchanged.
- PRESCALE=4: write LOAD=3, then CTRL=`0x5` (EN, IE, one-shot) → EXP and `INT` rise 16 cycles after the CTRL write edge.
  - CTRL then reads `0x4` and COUNT stays 0.
  - Writing STATUS=1 drops `INT` the next cycle.
- PRESCALE=4, LOAD=1, CTRL=`0x7` (periodic) → EXP sets every 8 cycles and COUNT cycles 1,0,1,0.
  - With IE cleared, `INT`=0 while EXP still reads 1.
- STATUS W1C issued exactly on an expiry tick → EXP reads 1 afterwards and `INT` stays high.
- Assert `RST_N` low mid-count with COUNT=`0x10` → COUNT, CTRL, and `INT` go to 0 immediately, before the next CLK edge.
  - No `INT` pulse after release.
